// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int unsigned GRP_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic [GRP_W-1:0] sum;
    logic             c3;
    logic             c4;
  } grp_res_t;

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Operand-side and result-side valid/ready handshake of cla_pipe_addsub.
interface cla_pipe_addsub_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: sum, internal carries and group P/G.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             cin,
  output logic [GRP_W-1:0] s,
  output logic             c3,
  output logic             c4,
  output logic             gp,
  output logic             gg
);

  logic [GRP_W-1:0] g;
  logic [GRP_W-1:0] p;
  logic [GRP_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of cin; no ripple between bits.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp   = &p;
  assign c[4] = gg | (gp & cin);

  assign s  = p ^ c[GRP_W-1:0];
  assign c3 = c[3];
  assign c4 = c[4];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor: one 4-bit group per stage, carry registered between stages.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  cla_pipe_addsub_if.slave bus
);

  localparam int unsigned NGRP = WIDTH / GRP_W;

  logic en;
  logic ovf_q;

  // A stalled sink freezes the whole pipe, bubbles included.
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    localparam int unsigned OPW = WIDTH - GRP_W * k;
    localparam int unsigned SW  = GRP_W * (k + 1);

    logic [OPW-1:0]   op_a;
    logic [OPW-1:0]   op_b;
    logic             cin;
    logic             vin;
    logic [SW-1:0]    sum_d;
    logic [SW-1:0]    sum_q;
    logic [GRP_W-1:0] grp_s;
    logic             grp_c3;
    logic             grp_c4;
    logic             gp;
    logic             gg;
    grp_res_t         res;
    logic             vld_q;
    logic             cy_q;

    cla_group4 u_grp (
      .a   (op_a[GRP_W-1:0]),
      .b   (op_b[GRP_W-1:0]),
      .cin (cin),
      .s   (grp_s),
      .c3  (grp_c3),
      .c4  (grp_c4),
      .gp  (gp),
      .gg  (gg)
    );

    assign res = {grp_s, grp_c3, grp_c4};

    if (k == 0) begin : g_head
      assign op_a  = bus.in_a;
      assign op_b  = (bus.in_sub == OP_ADD) ? bus.in_b : ~bus.in_b;
      assign cin   = (bus.in_sub == OP_SUB);
      assign vin   = bus.in_valid;
      assign sum_d = res.sum;
    end else begin : g_body
      // Skew: operand bits of groups k and above, waiting for their stage.
      logic [OPW-1:0] skew_a_q;
      logic [OPW-1:0] skew_b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skew_a_q <= '0;
          skew_b_q <= '0;
        end else if (en && g_stage[k-1].vin) begin
          skew_a_q <= g_stage[k-1].op_a[OPW+GRP_W-1:GRP_W];
          skew_b_q <= g_stage[k-1].op_b[OPW+GRP_W-1:GRP_W];
        end
      end

      assign op_a  = skew_a_q;
      assign op_b  = skew_b_q;
      assign cin   = g_stage[k-1].cy_q;
      assign vin   = g_stage[k-1].vld_q;
      assign sum_d = {res.sum, g_stage[k-1].sum_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        vld_q <= vin;
        if (vin) begin
          cy_q  <= gg | (gp & cin);
          sum_q <= sum_d;
        end
      end
    end

    // c3/c4 only matter for overflow at the top group.
    if (k == NGRP - 1) begin : g_tail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en && vin) begin
          ovf_q <= res.c3 ^ res.c4;
        end
      end
    end else begin : g_mid
      logic unused_c;
      assign unused_c = res.c3 ^ res.c4;
    end
  end

  assign bus.out_valid = g_stage[NGRP-1].vld_q;
  assign bus.out_sum   = g_stage[NGRP-1].sum_q;
  assign bus.out_cout  = g_stage[NGRP-1].cy_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 4-bit CLA. Operands of WIDTH bits are split into 4-bit lookahead groups. Each group is evaluated in its own pipeline stage, with the group carry registered between stages. The block sits between an operand source and a result sink in the datapath, with a valid/ready handshake on both sides, and reports sum, carry-out and signed overflow.

## Interface
- WIDTH, default 16: operand width; a multiple of 4, minimum 4.
- NGRP, default WIDTH/4: derived localparam, not overridable; number of groups, which is also the pipeline depth.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result beat present.
- out_ready  input  1  sink accepts the result.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_cout  output  1  carry out of the MSB. For subtract, 1 = no borrow.
- out_ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Subtraction is A + ~B + 1. B is inverted and the group-0 carry-in is set to in_sub at acceptance.
- Group k covers bits [4k+3:4k]. Within a group: G = a&b, P = a^b, and the carries c1..c4 come from full lookahead, not ripple. Sum bit i = P[i] ^ c[i].
- Stage k evaluates group k using the registered carry from stage k−1.
- Operand bits of higher groups travel through skew registers until their stage.
- Result bits of lower groups travel through de-skew registers so that all of out_sum leaves in the same beat.
- Overflow uses group NGRP−1's internal c3 (carry into MSB) and c4 (carry out of MSB). Both are captured in the final stage.
- Every pipeline stage carries a valid bit. Empty stages (bubbles) flow through the pipe and are not squeezed out.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en.
- When en = 0, every stage register holds, out_* are held stable, and no beat is accepted.
- A beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- When a result is consumed and a new beat is accepted in the same cycle, the pipe advances by one stage. Full throughput is one beat per cycle.
- Inputs are not sampled when in_valid = 0, and the stage-0 valid bit is loaded with 0.

## Timing
- Reset (asynchronous on rst_n low):
  - all valid bits = 0, so out_valid = 0 and in_ready = 1;
  - out_sum = 0, out_cout = 0, out_ovf = 0;
  - skew, de-skew and carry registers = 0.
- Reset asserted mid-operation discards all in-flight beats. The first cycle after rst_n rises behaves as an empty pipe.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+NGRP−1, i.e. NGRP cycles later when there is no stall. For WIDTH=4 this is 1 cycle; for WIDTH=16 it is 4 cycles.
- Each stall cycle (en = 0) adds exactly one cycle of latency to every in-flight beat.
- out_* are registered outputs. in_ready is combinational from out_valid/out_ready only; it has no path from in_*.
- Critical path per stage is one 4-bit lookahead group plus the carry register setup. It is independent of WIDTH.

## Structure
- Package cla_pkg:
  - GRP_W = 4;
  - mode constants OP_ADD = 1'b0, OP_SUB = 1'b1;
  - a typedef for the group result {sum[3:0], c3, c4}.
- Sub-module cla_group4 (combinational):
  - inputs: a[3:0], b[3:0], cin;
  - outputs: s[3:0], c3, c4, gp (group propagate), gg (group generate);
  - instantiated NGRP times inside a generate loop.
- The top level contains only the stage registers, the valid chain, the skew/de-skew arrays and the enable logic.

## Test plan
- WIDTH=16, add 0x7FFF + 0x0001 → after 4 cycles: out_sum = 0x8000, cout = 0, ovf = 1.
- WIDTH=16, sub 0x0000 − 0x0001 → out_sum = 0xFFFF, cout = 0, ovf = 0.
- WIDTH=16, sub 0x8000 − 0x0001 → out_sum = 0x7FFF, cout = 1, ovf = 1.
- WIDTH=16, add 0xFFFF + 0x0001 → out_sum = 0x0000, cout = 1, ovf = 0.
- Streaming: 8 back-to-back beats with out_ready = 1 → 8 consecutive out_valid cycles, results in order.
- Backpressure: hold out_ready = 0 for 3 cycles while the pipe is full.
  - Required: in_ready = 0, out_* stable, no beat lost or duplicated.
  - Then assert rst_n = 0 for one cycle. Required: out_valid = 0, out_sum = 0, in_ready = 1.
- WIDTH=4, exhaustive sweep of all 256 A/B combinations × add/sub → every result matches the reference model (sum, cout, ovf) with 1-cycle latency.
